// File: rtl/y86_execute_stage.sv
// y86_execute_stage: Execute (E) stage of a Y86-64 pipeline.
//  Picks the ALU operands and function from the E-register fields and drives them to an
//  external 64-bit ALU. It also keeps the condition codes (ZF/SF/OF), evaluates jXX/cmovXX
//  conditions and holds the E->M pipeline register.
// Ports:
//  clk, reset                        clock, async active-high reset
//  E_icode/ifun/valA/valB/valC       E-register fields
//  E_dstE/dstM/stat                  E-register destinations and status
//  m_stat, W_stat                    downstream status, used to block CC writes
//  M_stall, M_bubble                 M-register control (stall wins over bubble)
//  alu_x/alu_y/alu_ctrl              ALU request; alu_out/alu_of are the ALU result
//  cc_zf/cc_sf/cc_of                 registered condition codes
//  e_cnd, e_valE, e_dstE             combinational condition and forwarding sources
//  M_*                               M pipeline register outputs
module y86_execute_stage #(
  parameter int unsigned W     = 64,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [1:0]   E_stat,
  input  logic [1:0]   m_stat,
  input  logic [1:0]   W_stat,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic [1:0]   alu_ctrl,
  input  logic [W-1:0] alu_out,
  input  logic         alu_of,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         e_cnd,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic [1:0]   M_stat
);

  localparam logic [1:0]   StatAok  = 2'd0;
  localparam logic [3:0]   IcNop    = 4'h1;
  localparam logic [3:0]   IcCmov   = 4'h2;
  localparam logic [3:0]   IcOpq    = 4'h6;
  localparam logic [W-1:0] Eight    = W'(8);
  localparam logic [W-1:0] NegEight = '1 << 3;

  logic         r_zf, r_sf, r_of;
  logic [3:0]   r_icode, r_dste, r_dstm;
  logic         r_cnd;
  logic [W-1:0] r_vale, r_vala;
  logic [1:0]   r_stat;
  logic         w_set_cc;
  logic         w_cnd;
  logic [W-1:0] w_alua, w_alub;

  // Operand selection
  always_comb begin
    w_alua = '0;
    unique case (E_icode)
      4'h2, 4'h6:       w_alua = E_valA;
      4'h3, 4'h4, 4'h5: w_alua = E_valC;
      4'h8, 4'hA:       w_alua = NegEight;
      4'h9, 4'hB:       w_alua = Eight;
      default:          w_alua = '0;
    endcase
    w_alub = '0;
    unique case (E_icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: w_alub = E_valB;
      default:                                  w_alub = '0;
    endcase
  end

  assign alu_x    = w_alub;
  assign alu_y    = w_alua;
  assign alu_ctrl = (E_icode == IcOpq) ? E_ifun[1:0] : 2'b00;

  // Any exception in flight downstream blocks CC writes so younger ops cannot corrupt state
  assign w_set_cc = (E_icode == IcOpq) && (E_stat == StatAok) && (m_stat == StatAok) &&
                    (W_stat == StatAok) && !M_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_set_cc) begin
      r_zf <= (alu_out == '0);
      r_sf <= alu_out[W-1];
      // Logical ops (and/xor) always clear OF
      r_of <= E_ifun[1] ? 1'b0 : alu_of;
    end
  end

  assign cc_zf = r_zf;
  assign cc_sf = r_sf;
  assign cc_of = r_of;

  // Condition uses the registered CC, i.e. the result of an older OPQ
  always_comb begin
    w_cnd = 1'b0;
    unique case (E_ifun)
      4'h0:    w_cnd = 1'b1;
      4'h1:    w_cnd = (r_sf ^ r_of) | r_zf;
      4'h2:    w_cnd = r_sf ^ r_of;
      4'h3:    w_cnd = r_zf;
      4'h4:    w_cnd = ~r_zf;
      4'h5:    w_cnd = ~(r_sf ^ r_of);
      4'h6:    w_cnd = ~(r_sf ^ r_of) & ~r_zf;
      default: w_cnd = 1'b0;
    endcase
  end

  assign e_cnd  = w_cnd;
  assign e_valE = alu_out;
  assign e_dstE = ((E_icode == IcCmov) && !w_cnd) ? RNONE : E_dstE;

  // E->M register: stall > bubble > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_icode <= IcNop;
      r_cnd   <= 1'b0;
      r_vale  <= '0;
      r_vala  <= '0;
      r_dste  <= RNONE;
      r_dstm  <= RNONE;
      r_stat  <= StatAok;
    end else if (M_stall) begin
      r_icode <= r_icode;
    end else if (M_bubble) begin
      r_icode <= IcNop;
      r_cnd   <= 1'b0;
      r_vale  <= '0;
      r_vala  <= '0;
      r_dste  <= RNONE;
      r_dstm  <= RNONE;
      r_stat  <= StatAok;
    end else begin
      r_icode <= E_icode;
      r_cnd   <= w_cnd;
      r_vale  <= alu_out;
      r_vala  <= E_valA;
      r_dste  <= e_dstE;
      r_dstm  <= E_dstM;
      r_stat  <= E_stat;
    end
  end

  assign M_icode = r_icode;
  assign M_cnd   = r_cnd;
  assign M_valE  = r_vale;
  assign M_valA  = r_vala;
  assign M_dstE  = r_dste;
  assign M_dstM  = r_dstm;
  assign M_stat  = r_stat;

endmodule

// File: tb/tb_y86_execute_stage.sv
module tb_y86_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [1:0]  E_stat, m_stat, W_stat;
  logic        M_stall, M_bubble;
  logic [63:0] alu_x, alu_y, alu_out;
  logic [1:0]  alu_ctrl;
  logic        alu_of;
  logic        cc_zf, cc_sf, cc_of, e_cnd, M_cnd;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic [1:0]  M_stat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    alu_out = '0;
    alu_of  = 1'b0;
    case (alu_ctrl)
      2'b00: begin
        alu_out = alu_x + alu_y;
        alu_of  = (alu_x[63] == alu_y[63]) && (alu_out[63] != alu_x[63]);
      end
      2'b01: begin
        alu_out = alu_x - alu_y;
        alu_of  = (alu_x[63] != alu_y[63]) && (alu_out[63] != alu_x[63]);
      end
      2'b10:   alu_out = alu_x & alu_y;
      default: alu_out = alu_x ^ alu_y;
    endcase
  end

  y86_execute_stage dut (
    .clk(clk), .reset(reset),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_stat(E_stat), .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_of(alu_of),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .e_cnd(e_cnd), .e_valE(e_valE), .e_dstE(e_dstE),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] de, input logic [3:0] dm);
    E_icode = icode; E_ifun = ifun; E_valA = va; E_valB = vb; E_valC = vc;
    E_dstE = de; E_dstM = dm;
  endtask

  task automatic check_cc(input string tag, input logic z, input logic s, input logic o);
    check({tag, ".cc"}, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, z, s, o});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    E_stat = 2'd0; m_stat = 2'd0; W_stat = 2'd0; M_stall = 1'b0; M_bubble = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_cc("reset", 1'b1, 1'b0, 1'b0);
    check("reset.M_icode", 64'(M_icode), 64'h1);
    check("reset.M_dstE", 64'(M_dstE), 64'hF);
    check("reset.M_valE", M_valE, 64'h0);

    // OPQ add overflowing into the sign bit
    @(negedge clk);
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h2, 4'hF);
    #1;
    check("add.alu_x", alu_x, 64'h1);
    check("add.alu_y", alu_y, 64'h7FFF_FFFF_FFFF_FFFF);
    check("add.ctrl", 64'(alu_ctrl), 64'h0);
    check("add.e_dstE", 64'(e_dstE), 64'h2);
    step();
    check("add.M_valE", M_valE, 64'h8000_0000_0000_0000);
    check("add.M_icode", 64'(M_icode), 64'h6);
    check("add.M_dstE", 64'(M_dstE), 64'h2);
    check_cc("add", 1'b0, 1'b1, 1'b1);

    // OPQ sub equal operands, then jXX on ZF
    @(negedge clk);
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'h0, 4'h3, 4'hF);
    #1;
    check("sub.ctrl", 64'(alu_ctrl), 64'h1);
    check("sub.e_valE", e_valE, 64'h0);
    step();
    check("sub.M_valE", M_valE, 64'h0);
    check_cc("sub", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(4'h7, 4'h3, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
    #1;
    check("je.e_cnd", 64'(e_cnd), 64'h1);
    check("je.ctrl", 64'(alu_ctrl), 64'h0);
    E_ifun = 4'h4;
    #1;
    check("jne.e_cnd", 64'(e_cnd), 64'h0);

    // cmovl with SF=OF=0 is suppressed
    @(negedge clk);
    drive(4'h2, 4'h2, 64'h1234, 64'h0, 64'h0, 4'h3, 4'hF);
    #1;
    check("cmov0.e_dstE", 64'(e_dstE), 64'hF);
    step();
    check("cmov0.M_dstE", 64'(M_dstE), 64'hF);
    check("cmov0.M_cnd", 64'(M_cnd), 64'h0);

    // 0-1 gives SF=1, OF=0
    @(negedge clk);
    drive(4'h6, 4'h1, 64'd1, 64'd0, 64'h0, 4'h4, 4'hF);
    step();
    check_cc("neg", 1'b0, 1'b1, 1'b0);
    check("neg.M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    drive(4'h2, 4'h2, 64'h1234, 64'h0, 64'h0, 4'h3, 4'hF);
    #1;
    check("cmov1.e_cnd", 64'(e_cnd), 64'h1);
    step();
    check("cmov1.M_dstE", 64'(M_dstE), 64'h3);
    check("cmov1.M_valE", M_valE, 64'h1234);
    check("cmov1.M_cnd", 64'(M_cnd), 64'h1);

    // Stack pointer arithmetic
    @(negedge clk);
    drive(4'h8, 4'h0, 64'h0, 64'h100, 64'h200, 4'h4, 4'hF);
    #1;
    check("call.alu_y", alu_y, 64'hFFFF_FFFF_FFFF_FFF8);
    check("call.ctrl", 64'(alu_ctrl), 64'h0);
    step();
    check("call.M_valE", M_valE, 64'hF8);
    @(negedge clk);
    drive(4'hB, 4'h0, 64'h0, 64'hF8, 64'h0, 4'h4, 4'h5);
    step();
    check("pop.M_valE", M_valE, 64'h100);
    check("pop.M_dstM", 64'(M_dstM), 64'h5);
    @(negedge clk);
    drive(4'h3, 4'h0, 64'h9, 64'h77, 64'h55, 4'h6, 4'hF);
    #1;
    check("irmov.alu_x", alu_x, 64'h0);
    check("irmov.e_valE", e_valE, 64'h55);
    check_cc("irmov", 1'b0, 1'b1, 1'b0);

    // CC blocked by exceptions and stall; M still loads on exception
    @(negedge clk);
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'h0, 4'h2, 4'hF);
    m_stat = 2'd2;
    step();
    check_cc("madr", 1'b0, 1'b1, 1'b0);
    check("madr.M_icode", 64'(M_icode), 64'h6);
    check("madr.M_valA", M_valA, 64'h5);
    @(negedge clk);
    m_stat = 2'd0; W_stat = 2'd1;
    step();
    check_cc("whlt", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    W_stat = 2'd0; M_stall = 1'b1;
    drive(4'h6, 4'h3, 64'd3, 64'd5, 64'h0, 4'h7, 4'hF);
    step();
    check_cc("stall", 1'b0, 1'b1, 1'b0);
    check("stall.M_valA", M_valA, 64'h5);
    check("stall.M_dstE", 64'(M_dstE), 64'h2);
    @(negedge clk);
    M_bubble = 1'b1;
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    step();
    check("stallbub.M_icode", 64'(M_icode), 64'h6);
    @(negedge clk);
    M_stall = 1'b0;
    step();
    check("bubble.M_icode", 64'(M_icode), 64'h1);
    check("bubble.M_dstE", 64'(M_dstE), 64'hF);
    check("bubble.M_valA", M_valA, 64'h0);

    // Async reset in the middle of a cycle
    @(negedge clk);
    M_bubble = 1'b0; E_stat = 2'd2;
    drive(4'h6, 4'h0, 64'd2, 64'd3, 64'h0, 4'h1, 4'hF);
    step();
    check("pre.M_stat", 64'(M_stat), 64'h2);
    check("pre.M_valE", M_valE, 64'h5);
    #2;
    reset = 1'b1;
    #1;
    check_cc("mreset", 1'b1, 1'b0, 1'b0);
    check("mreset.M_icode", 64'(M_icode), 64'h1);
    check("mreset.M_dstE", 64'(M_dstE), 64'hF);
    check("mreset.M_stat", 64'(M_stat), 64'h0);
    check("mreset.M_valE", M_valE, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
